// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) for the MIPS32 execute stage.
// Radix-2 shift-add multiply and restoring divide, 32 iterations, writing the HI/LO registers.
module mul_div_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        hi_wen,
  output logic [31:0] hi_wdata,
  output logic        lo_wen,
  output logic [31:0] lo_wdata
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           sign_a_q, sign_a_d;
  logic           sign_b_q, sign_b_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wen_q, wen_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_abs, b_abs;
  logic [W:0]     sum;
  logic [2*W-1:0] mul_step;
  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           qbit;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;
  logic           res_neg;
  logic           div_zero;
  logic [2*W-1:0] mul_res;
  logic [W-1:0]   quo_res;
  logic [W-1:0]   rem_res;

  // Operand conditioning at acceptance: op[0]=1 selects the unsigned variants.
  always_comb begin
    a_neg = ~op[0] & src_a[W-1];
    b_neg = ~op[0] & src_b[W-1];
    a_abs = a_neg ? (W'(0) - src_a) : src_a;
    b_abs = b_neg ? (W'(0) - src_b) : src_b;
  end

  // One iteration of each algorithm; the final iteration feeds the sign fix-up directly.
  always_comb begin
    sum      = {1'b0, prod_q[2*W-1:W]} + {1'b0, opnd_q};
    mul_step = prod_q[0] ? {sum, prod_q[W-1:1]} : {1'b0, prod_q[2*W-1:1]};

    shifted  = {rem_q, prod_q[W-1]};
    trial    = shifted - {1'b0, opnd_q};
    qbit     = ~trial[W];
    rem_step = qbit ? trial[W-1:0] : shifted[W-1:0];
    quo_step = {prod_q[W-2:0], qbit};

    res_neg  = sign_a_q ^ sign_b_q;
    div_zero = (opnd_q == '0);
    mul_res  = res_neg ? ((2*W)'(0) - mul_step) : mul_step;
    if (div_zero) begin
      quo_res = quo_step;
      rem_res = rem_step;
    end else begin
      quo_res = res_neg  ? (W'(0) - quo_step) : quo_step;
      rem_res = sign_a_q ? (W'(0) - rem_step) : rem_step;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d  = ST_CALC;
          op_d     = op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          // Multiply: opnd = multiplicand, prod low = multiplier.
          // Divide:   opnd = divisor,      prod low = dividend (becomes quotient).
          opnd_d   = op[1] ? b_abs : a_abs;
          prod_d   = {W'(0), (op[1] ? a_abs : b_abs)};
          rem_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (op_q[1]) begin
            prod_d = {prod_q[2*W-1:W], quo_step};
            rem_d  = rem_step;
          end else begin
            prod_d = mul_step;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            wen_d   = 1'b1;
            if (op_q[1]) begin
              hi_d = rem_res;
              lo_d = quo_res;
            end else begin
              hi_d = mul_res[2*W-1:W];
              lo_d = mul_res[W-1:0];
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wen_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wen_q    <= wen_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // A flush during the write cycle must still suppress the HI/LO write.
  assign busy     = busy_q;
  assign done     = done_q & ~flush;
  assign hi_wen   = wen_q & ~flush;
  assign lo_wen   = wen_q & ~flush;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS32 execute stage. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles. It drives the write ports of the HI and LO special registers directly downstream: `hi_wen`/`hi_wdata` feed the HI register and `lo_wen`/`lo_wdata` feed the LO register. While it works, the unit holds `busy` so the pipeline control can stall MFHI/MFLO and further multiply/divide instructions.

## Interface

Parameters:
- `ITER`, 32: iteration count. Fixed at 32; no other value is supported.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request; sampled only in IDLE
- `op`  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a`  input  32  rs operand (multiplicand / dividend)
- `src_b`  input  32  rt operand (multiplier / divisor)
- `flush`  input  1  abort the operation in flight (exception or branch squash)
- `busy`  output  1  high whenever the unit is not in IDLE
- `done`  output  1  one-cycle pulse when the result is written
- `hi_wen`  output  1  HI write enable
- `hi_wdata`  output  32  HI write data
- `lo_wen`  output  1  LO write enable
- `lo_wdata`  output  32  LO write data

## Operation

- There are three states: IDLE, CALC and DONE.
- IDLE -> CALC when `start`=1 and `flush`=0:
  - Latch `op` and the operand signs.
  - For signed ops (MULT, DIV), latch the two's-complement absolute values of `src_a` and `src_b`. For unsigned ops, latch the raw values.
  - Clear the 6-bit iteration counter.
- CALC, multiply: radix-2 shift-add over a 64-bit product register. Each cycle, bit 0 of the multiplier conditionally adds the multiplicand into the upper half, then the register shifts right by 1.
- CALC, divide: restoring division. A 33-bit partial remainder and the quotient are shifted left by one per cycle. The quotient bit is 1 when the trial subtract is non-negative.
- CALC -> DONE after exactly 32 CALC cycles (counter reaches 31).
- DONE, sign fix-up:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Arithmetic wraps at 32/64 bits.
- DONE, result routing:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: HI = remainder, LO = quotient.
- DONE outputs: `hi_wen`=`lo_wen`=`done`=1 for exactly one cycle, then -> IDLE.
- Divide by zero is not trapped: LO = 0xFFFFFFFF and HI = `src_a` as latched, for both DIV and DIVU. For DIV, no sign fix-up is applied to this result.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `flush`=1 in CALC or DONE -> IDLE on the next edge, with `hi_wen`/`lo_wen`/`done` forced 0 in that cycle. HI and LO are never written for a flushed operation.
- `flush` together with `start` in IDLE: the request is ignored.
- `start` while `busy`=1 is ignored; the operation in flight continues unaffected.
- Operand changes after acceptance have no effect.

## Timing

- Reset state: IDLE, `busy`=0, `done`=0, `hi_wen`=0, `lo_wen`=0, `hi_wdata`=0, `lo_wdata`=0, all internal registers 0.
- Reset takes effect immediately, mid-operation included, and no write is issued.
- `start` sampled at the end of cycle 0:
  - CALC occupies cycles 1–32.
  - DONE is cycle 33, with the write enables and data valid in that cycle.
  - HI/LO hold the new values from cycle 34.
- `busy` is high in cycles 1–33.
- The earliest next accepted `start` is in cycle 34, giving a back-to-back throughput of one operation per 34 cycles.
- `hi_wdata`/`lo_wdata` are registered outputs. Outside DONE they hold their last value, but they are only meaningful while the write enables are high.
- `hi_wen` and `lo_wen` are always asserted together in this block.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 -> cycle 33: `hi_wdata`=0xFFFFFFFE, `lo_wdata`=0x00000001, `hi_wen`=`lo_wen`=`done`=1 for one cycle; `busy` high in cycles 1–33 only.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV −7 / 2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 and DIV 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678, with 34-cycle latency unchanged.
- Start MULT 5×6, pulse `start` again at cycle 10 with different operands, pulse `flush` at cycle 20 -> no write ever, `busy` low from cycle 21. A new start at cycle 21 completes normally with its own result.
- Assert `rst` at cycle 15 of a DIVU -> all outputs 0 immediately, no write. A new start after reset release gives the correct result.
